// File: rtl/sopc_pkg.sv
// Shared types and constants for the boot-time system-ID checker.
// Holds the FSM state type, status word bit positions and status slave addresses.
package sopc_pkg;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        DONE  = 2'd3
    } sysid_state_t;

    localparam int STAT_DONE    = 0;
    localparam int STAT_PASS    = 1;
    localparam int STAT_ID_OK   = 2;
    localparam int STAT_TS_OK   = 3;
    localparam int STAT_TIMEOUT = 4;

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_ID_Q   = 2'd1;
    localparam logic [1:0] ADDR_TS_Q   = 2'd2;
    localparam logic [1:0] ADDR_EXP_ID = 2'd3;

endpackage

// File: rtl/sopc_stall_timer.sv
// Small reloadable counter with a terminal-count flag, stepping up or down on enable.
// Used both as the startup delay and as the waitrequest timeout.
module sopc_stall_timer #(
    parameter int WIDTH      = 16,
    parameter int START      = 0,
    parameter int TERMINAL   = 0,
    parameter bit COUNT_DOWN = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [WIDTH-1:0] count;

    // The counter parks at the terminal value until it is cleared again.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= WIDTH'(START);
        end else if (enable && !tc) begin
            count <= COUNT_DOWN ? count - WIDTH'(1) : count + WIDTH'(1);
        end
    end

    assign tc = (count == WIDTH'(TERMINAL));

endmodule

// File: rtl/sopc_sysid_checker.sv
// Reads the sysid ID and timestamp words after reset, compares them with build-time
// constants and exposes the verdict on a status slave and two sideband pins.
module sopc_sysid_checker
    import sopc_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h65AA_D66E,
    parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
    parameter logic        ID_ADDR        = 1'b1,
    parameter logic        TS_ADDR        = 1'b0,
    parameter int          STARTUP_DELAY  = 16,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    output logic        m_address,
    output logic        m_read,
    input  logic [31:0] m_readdata,
    input  logic        m_waitrequest,
    input  logic [1:0]  s_address,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic        check_done,
    output logic        check_pass
);

    localparam int TO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    sysid_state_t state;
    sysid_state_t next_state;

    logic [31:0] id_q;
    logic [31:0] ts_q;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout;
    logic        restart;
    logic        accept;
    logic        stall_expired;
    logic        start_tc;
    logic        to_tc;
    logic [31:0] status_word;
    logic        unused_writedata;

    assign restart          = s_write && (s_address == ADDR_STATUS) && s_writedata[0];
    assign unused_writedata = ^s_writedata[31:1];

    assign m_read        = (state == RD_ID) || (state == RD_TS);
    assign m_address     = (state == RD_TS) ? TS_ADDR : ID_ADDR;
    assign accept        = m_read && !m_waitrequest;
    assign stall_expired = m_read && m_waitrequest && to_tc;

    sopc_stall_timer #(
        .WIDTH      (16),
        .START      (STARTUP_DELAY - 1),
        .TERMINAL   (0),
        .COUNT_DOWN (1'b1)
    ) u_startup (
        .clock  (clock),
        .reset  (reset),
        .clear  (restart),
        .enable (state == WAIT),
        .tc     (start_tc)
    );

    // Cleared on every state change so each read gets its own stall budget.
    sopc_stall_timer #(
        .WIDTH      (TO_WIDTH),
        .START      (0),
        .TERMINAL   (TIMEOUT_CYCLES - 1),
        .COUNT_DOWN (1'b0)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (restart || (next_state != state)),
        .enable (m_read && m_waitrequest),
        .tc     (to_tc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= WAIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            WAIT:  if (start_tc) next_state = RD_ID;
            RD_ID: begin
                if (!m_waitrequest) begin
                    next_state = RD_TS;
                end else if (to_tc) begin
                    next_state = DONE;
                end
            end
            RD_TS: if (!m_waitrequest || to_tc) next_state = DONE;
            DONE:  next_state = DONE;
            default: next_state = WAIT;
        endcase
        if (restart) begin
            next_state = WAIT;
        end
    end

    // Restart takes priority over a read accepted in the same cycle.
    always_ff @(posedge clock) begin
        if (reset || restart) begin
            id_q       <= '0;
            ts_q       <= '0;
            id_ok      <= 1'b0;
            ts_ok      <= 1'b0;
            timeout    <= 1'b0;
            check_done <= 1'b0;
            check_pass <= 1'b0;
        end else begin
            case (state)
                RD_ID: begin
                    if (accept) begin
                        id_q  <= m_readdata;
                        id_ok <= (m_readdata == EXPECTED_ID);
                    end else if (stall_expired) begin
                        timeout    <= 1'b1;
                        check_done <= 1'b1;
                    end
                end
                RD_TS: begin
                    if (accept) begin
                        ts_q       <= m_readdata;
                        ts_ok      <= (m_readdata == EXPECTED_TS);
                        check_done <= 1'b1;
                        check_pass <= id_ok && (m_readdata == EXPECTED_TS);
                    end else if (stall_expired) begin
                        timeout    <= 1'b1;
                        check_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        status_word               = '0;
        status_word[STAT_DONE]    = check_done;
        status_word[STAT_PASS]    = check_pass;
        status_word[STAT_ID_OK]   = id_ok;
        status_word[STAT_TS_OK]   = ts_ok;
        status_word[STAT_TIMEOUT] = timeout;
    end

    // Read data reflects the pre-write contents when a read and a write coincide.
    always_ff @(posedge clock) begin
        if (reset) begin
            s_readdata <= '0;
        end else if (s_read) begin
            case (s_address)
                ADDR_STATUS: s_readdata <= status_word;
                ADDR_ID_Q:   s_readdata <= id_q;
                ADDR_TS_Q:   s_readdata <= ts_q;
                ADDR_EXP_ID: s_readdata <= EXPECTED_ID;
                default:     s_readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sopc_sysid_checker.sv
// Scoreboard bench for sopc_sysid_checker: a sysid slave model with configurable stalls,
// expectation queues filled by the stimulus and drained by an independent monitor.
module tb_sopc_sysid_checker;

    localparam logic [31:0] EXP_ID  = 32'h65AA_D66E;
    localparam int          SDELAY  = 16;
    localparam int          TOUT    = 255;

    typedef struct {
        logic [31:0] value;
        string       name;
    } rd_exp_t;

    typedef struct {
        int   cycle;
        logic pass;
    } done_exp_t;

    logic        clock;
    logic        reset;
    logic        m_address;
    logic        m_read;
    logic [31:0] m_readdata;
    logic        m_waitrequest;
    logic [1:0]  s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic        check_done;
    logic        check_pass;

    logic [31:0] model_id;
    logic [31:0] model_ts;
    int          stall_n;
    bit          stuck;
    int          stall_cnt;

    int          n_compared;
    int          n_failed;
    int          since;
    logic        rd_pend;
    logic        stalled_prev;
    logic        addr_prev;
    logic        done_prev;
    logic        mread_prev;

    rd_exp_t     rd_q[$];
    done_exp_t   done_q[$];

    sopc_sysid_checker dut (
        .clock         (clock),
        .reset         (reset),
        .m_address     (m_address),
        .m_read        (m_read),
        .m_readdata    (m_readdata),
        .m_waitrequest (m_waitrequest),
        .s_address     (s_address),
        .s_read        (s_read),
        .s_write       (s_write),
        .s_writedata   (s_writedata),
        .s_readdata    (s_readdata),
        .check_done    (check_done),
        .check_pass    (check_pass)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign m_readdata    = m_address ? model_id : model_ts;
    assign m_waitrequest = m_read && (stuck || (stall_cnt < stall_n));

    always @(posedge clock) begin
        if (!m_read || !m_waitrequest) stall_cnt <= 0;
        else stall_cnt <= stall_cnt + 1;
    end

    // Edge bookkeeping: cycles since reset/restart, pending status reads, stall snapshot.
    always @(posedge clock) begin
        if (reset || (s_write && s_address == 2'd0 && s_writedata[0])) since <= 0;
        else since <= since + 1;
        rd_pend      <= s_read && !reset;
        stalled_prev <= (m_read === 1'b1) && (m_waitrequest === 1'b1) && !reset &&
                        !(s_write && s_address == 2'd0 && s_writedata[0]);
        addr_prev    <= m_address;
    end

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: drains the scoreboard queues whenever the DUT presents a response.
    always @(negedge clock) begin
        if (rd_pend) begin
            if (rd_q.size() == 0) begin
                compare("unexpected_read", 32'd1, 32'd0);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                compare(e.name, s_readdata, e.value);
            end
        end
        if (!reset && check_done === 1'b1 && done_prev !== 1'b1) begin
            if (done_q.size() == 0) begin
                compare("unexpected_done", 32'd1, 32'd0);
            end else begin
                done_exp_t d;
                d = done_q.pop_front();
                compare("done_cycle", 32'(since), 32'(d.cycle));
                compare("done_pass", {31'b0, check_pass}, {31'b0, d.pass});
            end
        end
        if (!reset && m_read === 1'b1 && mread_prev !== 1'b1) begin
            compare("m_read_delay", 32'(since), 32'(SDELAY));
        end
        if (stalled_prev && check_done !== 1'b1) begin
            compare("stall_m_read", {31'b0, m_read}, 32'd1);
            compare("stall_m_addr", {31'b0, m_address}, {31'b0, addr_prev});
        end
        done_prev  <= check_done;
        mread_prev <= m_read;
    end

    task automatic status_read(input logic [1:0] addr, input logic [31:0] exp, input string name);
        rd_exp_t e;
        e.value = exp;
        e.name  = name;
        rd_q.push_back(e);
        s_address = addr;
        s_read    = 1'b1;
        @(negedge clock);
        s_read    = 1'b0;
    endtask

    task automatic status_write(input logic [1:0] addr, input logic [31:0] data);
        s_address   = addr;
        s_writedata = data;
        s_write     = 1'b1;
        @(negedge clock);
        s_write     = 1'b0;
        s_writedata = '0;
    endtask

    task automatic expect_done(input int cycle, input logic pass);
        done_exp_t d;
        d.cycle = cycle;
        d.pass  = pass;
        done_q.push_back(d);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_q.size() == 0) break;
            @(negedge clock);
        end
        if (done_q.size() != 0) begin
            n_compared++;
            n_failed++;
            $display("[TB] FAIL wait_done: check_done not seen within %0d cycles", budget);
            done_q.delete();
        end
    endtask

    task automatic wait_for_read(input logic addr, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (m_read === 1'b1 && m_address === addr) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        n_compared++;
        if (!seen) begin
            n_failed++;
            $display("[TB] FAIL wait_for_read: address %0d not requested within %0d cycles", addr, budget);
        end
    endtask

    initial begin
        n_compared  = 0;
        n_failed    = 0;
        since       = 0;
        stall_cnt   = 0;
        reset       = 1'b1;
        s_address   = '0;
        s_read      = 1'b0;
        s_write     = 1'b0;
        s_writedata = '0;
        model_id    = EXP_ID;
        model_ts    = 32'h0;
        stall_n     = 0;
        stuck       = 1'b0;

        @(negedge clock);
        @(negedge clock);
        compare("rst_m_read", {31'b0, m_read}, 32'd0);
        compare("rst_m_addr", {31'b0, m_address}, 32'd1);
        compare("rst_done", {31'b0, check_done}, 32'd0);
        compare("rst_pass", {31'b0, check_pass}, 32'd0);
        compare("rst_readdata", s_readdata, 32'd0);

        $display("[TB] zero-wait matching sysid");
        expect_done(SDELAY + 2, 1'b1);
        reset = 1'b0;
        wait_done(100);
        status_read(2'd0, 32'h0000_000F, "stat_pass");
        status_read(2'd1, EXP_ID, "id_q_pass");
        status_read(2'd2, 32'h0, "ts_q_pass");
        status_read(2'd3, EXP_ID, "expected_id");

        $display("[TB] ignored writes and read/write collision");
        status_write(2'd1, 32'h1);
        status_write(2'd0, 32'h2);
        status_read(2'd0, 32'h0000_000F, "stat_ignored_wr");
        begin
            rd_exp_t e;
            e.value = 32'h0000_000F;
            e.name  = "rw_pre_write";
            rd_q.push_back(e);
        end
        expect_done(SDELAY + 2, 1'b1);
        s_address   = 2'd0;
        s_writedata = 32'h1;
        s_read      = 1'b1;
        s_write     = 1'b1;
        @(negedge clock);
        s_read      = 1'b0;
        s_write     = 1'b0;
        s_writedata = '0;
        wait_done(100);

        $display("[TB] wrong system ID");
        model_id = 32'hDEAD_BEEF;
        expect_done(SDELAY + 2, 1'b0);
        status_write(2'd0, 32'h1);
        wait_done(100);
        status_read(2'd0, 32'h0000_0009, "stat_bad_id");
        status_read(2'd1, 32'hDEAD_BEEF, "id_q_bad");

        $display("[TB] three stall cycles per read");
        model_id = EXP_ID;
        stall_n  = 3;
        expect_done(SDELAY + 8, 1'b1);
        status_write(2'd0, 32'h1);
        wait_done(100);
        status_read(2'd0, 32'h0000_000F, "stat_stall");

        $display("[TB] waitrequest stuck high");
        stuck = 1'b1;
        expect_done(SDELAY + TOUT, 1'b0);
        status_write(2'd0, 32'h1);
        wait_done(400);
        status_read(2'd0, 32'h0000_0011, "stat_timeout");
        status_read(2'd1, 32'h0, "id_q_timeout");

        $display("[TB] restart from DONE and mid-RD_TS under stall");
        stuck = 1'b0;
        expect_done(SDELAY + 8, 1'b1);
        status_write(2'd0, 32'h1);
        wait_done(100);
        status_write(2'd0, 32'h1);
        wait_for_read(1'b0, 100);
        status_write(2'd0, 32'h1);
        compare("abort_done", {31'b0, check_done}, 32'd0);
        compare("abort_m_read", {31'b0, m_read}, 32'd0);
        expect_done(SDELAY + 8, 1'b1);
        status_read(2'd0, 32'h0, "stat_abort");
        status_read(2'd2, 32'h0, "ts_q_abort");
        wait_done(100);

        $display("[TB] restart colliding with RD_TS accept");
        stall_n = 0;
        status_write(2'd0, 32'h1);
        wait_for_read(1'b0, 100);
        status_write(2'd0, 32'h1);
        expect_done(SDELAY + 2, 1'b1);
        status_read(2'd0, 32'h0, "stat_collide");
        wait_done(100);

        $display("[TB] reset during RD_ID");
        stall_n = 3;
        status_read(2'd3, EXP_ID, "expected_id_2");
        status_write(2'd0, 32'h1);
        wait_for_read(1'b1, 100);
        reset = 1'b1;
        @(negedge clock);
        compare("mid_rst_m_read", {31'b0, m_read}, 32'd0);
        compare("mid_rst_m_addr", {31'b0, m_address}, 32'd1);
        compare("mid_rst_readdata", s_readdata, 32'd0);
        compare("mid_rst_done", {31'b0, check_done}, 32'd0);
        compare("mid_rst_pass", {31'b0, check_pass}, 32'd0);
        expect_done(SDELAY + 8, 1'b1);
        reset = 1'b0;
        wait_done(100);
        status_read(2'd0, 32'h0000_000F, "stat_after_rst");

        @(negedge clock);
        @(negedge clock);
        if (rd_q.size() != 0) begin
            n_compared++;
            n_failed++;
            $display("[TB] FAIL pending_reads: %0d status reads never answered", rd_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
